// File: rtl/timer_ctrl.sv
// timer_ctrl: BCD MM:SS up/down timer with prescaler and IDLE/RUN/PAUSE/DONE control FSM
module timer_ctrl #(
    parameter int TICK_DIV = 50000000
) (
    input  logic        CP,
    input  logic        clear,
    input  logic        start,
    input  logic        pause,
    input  logic        load,
    input  logic        mode,
    input  logic [15:0] preset,
    output logic [3:0]  sec_lo,
    output logic [3:0]  sec_hi,
    output logic [3:0]  min_lo,
    output logic [3:0]  min_hi,
    output logic        tick,
    output logic        running,
    output logic        done,
    output logic [1:0]  state
);
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] P_MAX = W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;

    state_t     r_state, w_state_n;
    logic [W-1:0] r_presc;
    logic [3:0] r_sl, r_sh, r_ml, r_mh;
    logic [3:0] w_sl, w_sh, w_ml, w_mh;
    logic [3:0] w_ld_sl, w_ld_sh, w_ld_ml, w_ld_mh;
    logic       r_done;
    logic       w_c0, w_c1, w_c2, w_b0, w_b1, w_b2;
    logic       w_term, w_term_n, w_tick, w_load;

    assign w_c0 = r_sl == 4'd9;
    assign w_c1 = w_c0 && r_sh == 4'd5;
    assign w_c2 = w_c1 && r_ml == 4'd9;
    assign w_b0 = r_sl == 4'd0;
    assign w_b1 = w_b0 && r_sh == 4'd0;
    assign w_b2 = w_b1 && r_ml == 4'd0;

    // Digit values after one count step in the current direction
    assign w_sl = mode ? (w_b0 ? 4'd9 : r_sl - 4'd1) : (w_c0 ? 4'd0 : r_sl + 4'd1);
    assign w_sh = mode ? (w_b0 ? (r_sh == 4'd0 ? 4'd5 : r_sh - 4'd1) : r_sh)
                       : (w_c0 ? (r_sh == 4'd5 ? 4'd0 : r_sh + 4'd1) : r_sh);
    assign w_ml = mode ? (w_b1 ? (r_ml == 4'd0 ? 4'd9 : r_ml - 4'd1) : r_ml)
                       : (w_c1 ? (r_ml == 4'd9 ? 4'd0 : r_ml + 4'd1) : r_ml);
    assign w_mh = mode ? (w_b2 ? (r_mh == 4'd0 ? 4'd5 : r_mh - 4'd1) : r_mh)
                       : (w_c2 ? (r_mh == 4'd5 ? 4'd0 : r_mh + 4'd1) : r_mh);

    assign w_ld_sl = (preset[3:0]   > 4'd9) ? 4'd0 : preset[3:0];
    assign w_ld_sh = (preset[7:4]   > 4'd5) ? 4'd0 : preset[7:4];
    assign w_ld_ml = (preset[11:8]  > 4'd9) ? 4'd0 : preset[11:8];
    assign w_ld_mh = (preset[15:12] > 4'd5) ? 4'd0 : preset[15:12];

    assign w_term   = {r_mh, r_ml, r_sh, r_sl} == (mode ? 16'h0000 : 16'h5959);
    assign w_term_n = {w_mh, w_ml, w_sh, w_sl} == (mode ? 16'h0000 : 16'h5959);
    // A step is suppressed when already at terminal so the digits never run past it
    assign w_tick   = r_state == RUN && r_presc == P_MAX && !w_term;
    assign w_load   = load && r_state != RUN;

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    w_state_n = load ? IDLE : (start ? RUN : IDLE);
            RUN:     w_state_n = (w_term || (w_tick && w_term_n)) ? DONE : (pause ? PAUSE : RUN);
            PAUSE:   w_state_n = load ? IDLE : (start ? RUN : PAUSE);
            DONE:    w_state_n = (load || start) ? IDLE : DONE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge CP) begin
        if (clear) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_presc <= '0;
            {r_mh, r_ml, r_sh, r_sl} <= 16'h0000;
        end else begin
            r_state <= w_state_n;
            r_done  <= w_state_n == DONE && r_state != DONE;
            if (w_load || (r_state == IDLE && w_state_n == RUN))
                r_presc <= '0;
            else if (r_state == RUN)
                r_presc <= (r_presc == P_MAX) ? '0 : r_presc + W'(1);
            if (w_load)
                {r_mh, r_ml, r_sh, r_sl} <= {w_ld_mh, w_ld_ml, w_ld_sh, w_ld_sl};
            else if (w_tick)
                {r_mh, r_ml, r_sh, r_sl} <= {w_mh, w_ml, w_sh, w_sl};
        end
    end

    assign sec_lo  = r_sl;
    assign sec_hi  = r_sh;
    assign min_lo  = r_ml;
    assign min_hi  = r_mh;
    assign tick    = w_tick;
    assign running = r_state == RUN;
    assign done    = r_done;
    assign state   = r_state;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed and randomized checks of timer_ctrl against a seconds-based reference model
module tb_timer_ctrl;
    localparam int DIV = 4;

    logic        CP = 1'b0;
    logic        clear, start, pause, load, mode;
    logic [15:0] preset;
    logic [3:0]  sec_lo, sec_hi, min_lo, min_hi;
    logic        tick, running, done;
    logic [1:0]  state;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: state code, elapsed value in whole seconds, prescaler phase, done pulse
    int m_st, m_secs, m_ph;
    bit m_done;

    timer_ctrl #(.TICK_DIV(DIV)) dut (
        .CP(CP), .clear(clear), .start(start), .pause(pause), .load(load), .mode(mode),
        .preset(preset), .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
        .tick(tick), .running(running), .done(done), .state(state)
    );

    always #5 CP = ~CP;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int term_secs(input logic md);
        return md ? 0 : 3599;
    endfunction

    function automatic logic [15:0] bcd(input int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic int ld_secs(input logic [15:0] p);
        int mh, ml, sh, sl;
        mh = p[15:12] > 5 ? 0 : int'(p[15:12]);
        ml = p[11:8]  > 9 ? 0 : int'(p[11:8]);
        sh = p[7:4]   > 5 ? 0 : int'(p[7:4]);
        sl = p[3:0]   > 9 ? 0 : int'(p[3:0]);
        return mh * 600 + ml * 60 + sh * 10 + sl;
    endfunction

    function automatic bit exp_tick();
        return m_st == 1 && m_ph == DIV - 1 && m_secs != term_secs(mode);
    endfunction

    task automatic model_step();
        bit t, d;
        t = exp_tick();
        d = 1'b0;
        if (clear) begin
            m_st = 0; m_secs = 0; m_ph = 0;
        end else if (m_st == 1) begin
            if (m_secs == term_secs(mode)) begin
                m_st = 3; d = 1'b1; m_ph = (m_ph + 1) % DIV;
            end else if (t) begin
                m_secs = mode ? m_secs - 1 : m_secs + 1;
                m_ph = 0;
                if (m_secs == term_secs(mode)) begin m_st = 3; d = 1'b1; end
                else if (pause) m_st = 2;
            end else begin
                m_ph = m_ph + 1;
                if (pause) m_st = 2;
            end
        end else if (load) begin
            m_st = 0; m_secs = ld_secs(preset); m_ph = 0;
        end else if (start) begin
            if (m_st == 0) begin m_st = 1; m_ph = 0; end
            else m_st = (m_st == 2) ? 1 : 0;
        end
        m_done = d;
    endtask

    task automatic cyc(input logic c, input logic l, input logic s, input logic p,
                       input logic md, input logic [15:0] pre);
        clear = c; load = l; start = s; pause = p; mode = md; preset = pre;
        @(negedge CP);
        chk("state", 32'(state), 32'(m_st));
        chk("digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'(bcd(m_secs)));
        chk("tick", 32'(tick), 32'(exp_tick()));
        chk("running", 32'(running), 32'(m_st == 1));
        chk("done", 32'(done), 32'(m_done));
        model_step();
        @(posedge CP);
        #1;
    endtask

    task automatic idle(input int n, input logic md);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, md, 16'h0);
    endtask

    initial begin
        int r, ticks;
        logic [15:0] pre;
        clear = 1; load = 0; start = 0; pause = 0; mode = 0; preset = 16'h0;
        @(posedge CP);
        #1;
        m_st = 0; m_secs = 0; m_ph = 0; m_done = 0;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h0);

        // count up ten steps
        cyc(1, 0, 0, 0, 0, 16'h0);
        cyc(0, 0, 1, 0, 0, 16'h0);
        ticks = 0;
        for (int i = 0; i < 10 * DIV; i++) begin
            if (tick) ticks++;
            cyc(0, 0, 0, 0, 0, 16'h0);
        end
        chk("up10_ticks", 32'(ticks), 32'd10);
        chk("up10_digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h0010);
        chk("up10_running", 32'(running), 32'd1);

        // count down to 00:00
        cyc(1, 0, 0, 0, 1, 16'h0);
        cyc(0, 1, 0, 0, 1, 16'h0002);
        cyc(0, 0, 1, 0, 1, 16'h0);
        idle(2 * DIV, 1);
        chk("dn_state", 32'(state), 32'd3);
        chk("dn_done", 32'(done), 32'd1);
        chk("dn_digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h0);
        idle(1, 1);
        chk("dn_done_once", 32'(done), 32'd0);

        // pause holds digits and prescaler phase
        cyc(1, 0, 0, 0, 0, 16'h0);
        cyc(0, 1, 0, 0, 0, 16'h0003);
        cyc(0, 0, 1, 0, 0, 16'h0);
        idle(1, 0);
        cyc(0, 0, 0, 1, 0, 16'h0);
        idle(20, 0);
        chk("pause_state", 32'(state), 32'd2);
        chk("pause_digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h0003);
        cyc(0, 0, 1, 0, 0, 16'h0);
        chk("resume_no_tick", 32'(tick), 32'd0);
        idle(1, 0);
        chk("resume_tick", 32'(tick), 32'd1);
        idle(1, 0);
        chk("resume_digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h0004);

        // terminal 59:59 then back to IDLE holding digits
        cyc(0, 0, 0, 1, 0, 16'h0);
        cyc(0, 1, 0, 0, 0, 16'h5958);
        cyc(0, 0, 1, 0, 0, 16'h0);
        idle(DIV, 0);
        chk("top_state", 32'(state), 32'd3);
        chk("top_digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h5959);
        cyc(0, 0, 1, 0, 0, 16'h0);
        chk("top_idle", 32'(state), 32'd0);
        chk("top_held", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h5959);

        // start at terminal: one RUN cycle then DONE without a step
        cyc(0, 0, 1, 0, 0, 16'h0);
        chk("term_run", 32'(state), 32'd1);
        idle(1, 0);
        chk("term_done", 32'(state), 32'd3);

        // preset sanitising and load priority over start
        cyc(0, 1, 0, 0, 0, 16'h7A6B);
        chk("ld_invalid", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h0);
        cyc(0, 1, 0, 0, 0, 16'h09C9);
        chk("ld_partial", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h0909);
        cyc(0, 1, 1, 0, 0, 16'h0001);
        chk("ld_start", 32'(state), 32'd0);

        // clear wins over a tick and a start
        cyc(1, 0, 0, 0, 0, 16'h0);
        cyc(0, 0, 1, 0, 0, 16'h0);
        idle(DIV - 1, 0);
        chk("clr_pre_tick", 32'(tick), 32'd1);
        cyc(1, 0, 1, 0, 0, 16'h0);
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h0);
        chk("clr_outs", 32'({tick, running, done}), 32'h0);
        idle(2, 0);

        // randomized traffic
        for (int i = 0; i < 5000; i++) begin
            r = $urandom_range(3);
            pre = (r == 0) ? 16'($urandom) :
                  (r == 1) ? bcd($urandom_range(19)) :
                  (r == 2) ? bcd(3580 + $urandom_range(19)) : bcd($urandom_range(3599));
            cyc($urandom_range(199) == 0, $urandom_range(19) == 0, $urandom_range(5) == 0,
                $urandom_range(24) == 0, ($urandom_range(39) == 0) ? ~mode : mode, pre);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, CP cycles per one-second count step (legal range 2..2^26).
REQ-002 SHALL have port CP  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port clear  input  1  synchronous active-high reset.
REQ-004 SHALL have port start  input  1  start/resume/acknowledge request, sampled each cycle.
REQ-005 SHALL have port pause  input  1  pause request, sampled each cycle.
REQ-006 SHALL have port load  input  1  load preset request.
REQ-007 SHALL have port mode  input  1  0 = count up, 1 = count down; sampled on each tick.
REQ-008 SHALL have port preset  input  16  BCD MM:SS preset {min_hi, min_lo, sec_hi, sec_lo}.
REQ-009 SHALL have port sec_lo, sec_hi, min_lo, min_hi  output  4 each  current BCD digits.
REQ-010 SHALL have port tick  output  1  one-cycle pulse on each count step.
REQ-011 SHALL have port running  output  1  high while in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse on entry to DONE.
REQ-013 SHALL have port state  output  2  FSM state encoding.

Function
REQ-014 SHALL implement FSM IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-015 Input priority SHALL be clear > load > start > pause when asserted in the same cycle.
REQ-016 IDLE: start -> RUN; load -> IDLE with digits loaded.
REQ-017 RUN: pause -> PAUSE; load and start ignored; terminal reached -> DONE.
REQ-018 PAUSE: start -> RUN; load -> IDLE with digits loaded; digits and prescaler held.
REQ-019 DONE: start -> IDLE, digits unchanged; load -> IDLE with digits loaded.
REQ-020 Prescaler SHALL count 0..TICK_DIV-1 only in RUN, wrap to 0, assert tick in the cycle it equals TICK_DIV-1.
REQ-021 Prescaler SHALL clear to 0 on load and on IDLE->RUN; SHALL hold value across PAUSE.
REQ-022 On tick, mode=0 SHALL increment: sec_lo 9->0 carries to sec_hi, sec_hi 5->0 carries to min_lo, min_lo 9->0 carries to min_hi; all digits update in the tick's following edge.
REQ-023 On tick, mode=1 SHALL decrement with borrow: sec_lo 0->9, sec_hi 0->5, min_lo 0->9, min_hi 0->5.
REQ-024 Terminal SHALL be 59:59 for mode=0 and 00:00 for mode=1; the tick that produces the terminal value SHALL also move FSM to DONE and assert done on the next cycle.
REQ-025 On start in IDLE when digits already equal the terminal for current mode, FSM SHALL go RUN for one cycle then DONE, with no tick and no digit change.
REQ-026 Loaded digits exceeding their range (sec_lo/min_lo > 9, sec_hi/min_hi > 5) SHALL be stored as 0; valid digits stored unchanged.
REQ-027 Digits SHALL never leave their BCD range; no wrap past terminal.
REQ-028 running SHALL equal (state==RUN); done SHALL be exactly one cycle wide per DONE entry.
REQ-029 mode change mid-RUN SHALL take effect on the next tick; no other side effect.

Reset
REQ-030 clear SHALL set state=IDLE, all digits=0, prescaler=0, tick=0, done=0, running=0 on the next CP edge.
REQ-031 clear SHALL override every other input in any state, including mid-RUN and the cycle of a tick.

Verification (TICK_DIV=4)
REQ-032 clear; start, mode=0 -> tick every 4 cycles; after 10 ticks digits 00:10; running=1.
REQ-033 load preset=16'h0002, mode=1, start -> ticks produce 00:01, 00:00; done pulses once 1 cycle after second tick; state=11.
REQ-034 RUN at 00:03, pause after 2 prescaler cycles, hold 20 cycles, start -> next tick exactly 2 cycles after resume; digits unchanged during pause.
REQ-035 load preset=16'h5958, mode=0, start -> one tick to 59:59, then DONE; start -> IDLE with 59:59 held.
REQ-036 load preset=16'h7A6B -> digits 00:00 (all invalid); load preset=16'h09C9 -> 09:09 with sec_hi forced 0; load+start same cycle -> state IDLE.
REQ-037 clear asserted in the same cycle as a tick and a start -> all outputs 0, state=00, no done pulse.
